// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP slice: OPMODE field encodings and default widths.
// Pure declarations: no logic, no latency and no flow control.
package dsp_pkg;

    localparam int DEF_WIDTH  = 18;
    localparam int DEF_PWIDTH = 48;
    localparam int OPMODE_W   = 5;

    // X-mux select, OPMODE[1:0]
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    // Z-mux select, OPMODE[3:2]
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

    localparam int OP_SUB = 4;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable and async active-high clear.
// Latency is 1 cycle when ENABLE=1 and 0 when ENABLE=0; CE=0 holds, there is no backpressure.
module dsp_pipe_reg #(
    parameter int WIDTH  = 1,
    parameter bit ENABLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (ENABLE) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end else begin : g_wire
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_post_stage.sv
// Signed multiply, X/Z post-add/subtract with carry-in into the P accumulator, PCOUT cascade.
// Latency 1+MREG CE cycles from A/B/controls to P; CE=0 freezes every stage, with no backpressure.
module dsp_mac_post_stage
    import dsp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PWIDTH = DEF_PWIDTH,
    parameter bit MREG   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CE,
    input  logic                       in_valid,
    input  logic signed [WIDTH-1:0]    A,
    input  logic signed [WIDTH-1:0]    B,
    input  logic        [PWIDTH-1:0]   C,
    input  logic        [PWIDTH-1:0]   PCIN,
    input  logic        [OPMODE_W-1:0] OPMODE,
    input  logic                       CARRYIN,
    output logic        [PWIDTH-1:0]   P,
    output logic        [PWIDTH-1:0]   PCOUT,
    output logic                       CARRYOUT,
    output logic                       out_valid
);

    localparam int MW = 2 * WIDTH;
    localparam int CW = OPMODE_W + 1 + PWIDTH + PWIDTH + MW;

    logic signed [MW-1:0]       a_ext;
    logic signed [MW-1:0]       b_ext;
    logic signed [MW-1:0]       prod;
    logic        [MW-1:0]       m_q;
    logic        [CW-1:0]       ctrl_d;
    logic        [CW-1:0]       ctrl_q;
    logic        [OPMODE_W-1:0] op_q;
    logic                       cin_q;
    logic        [PWIDTH-1:0]   c_q;
    logic        [PWIDTH-1:0]   pcin_q;
    logic        [WIDTH-1:0]    a_q;
    logic        [WIDTH-1:0]    b_q;
    logic        [PWIDTH-1:0]   p_q;
    logic        [PWIDTH:0]     m_sext;
    logic        [PWIDTH-1:0]   dab;
    logic        [PWIDTH:0]     x_op;
    logic        [PWIDTH:0]     z_op;
    logic        [PWIDTH:0]     cin_ext;
    logic        [PWIDTH:0]     r;
    logic        [PWIDTH:0]     p_reg_q;
    logic                       v_m;

    assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};
    assign prod  = a_ext * b_ext;

    dsp_pipe_reg #(.WIDTH(MW), .ENABLE(MREG)) u_m_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CE),
        .d   (prod),
        .q   (m_q)
    );

    // Controls and the D:A:B operands travel with the product so the post-adder sees a matched set.
    assign ctrl_d = {OPMODE, CARRYIN, C, PCIN, A, B};

    dsp_pipe_reg #(.WIDTH(CW), .ENABLE(MREG)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CE),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    assign {op_q, cin_q, c_q, pcin_q, a_q, b_q} = ctrl_q;

    // The product is signed, so it is sign-extended through the carry bit; other operands are unsigned.
    assign m_sext  = {{(PWIDTH + 1 - MW){m_q[MW-1]}}, m_q};
    assign cin_ext = {{PWIDTH{1'b0}}, cin_q};

    always_comb begin
        dab          = c_q;
        dab[MW-1:0]  = {a_q, b_q};

        x_op = '0;
        case (op_q[1:0])
            X_ZERO:  x_op = '0;
            X_M:     x_op = m_sext;
            X_P:     x_op = {1'b0, p_q};
            X_DAB:   x_op = {1'b0, dab};
            default: x_op = '0;
        endcase

        z_op = '0;
        case (op_q[3:2])
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = {1'b0, pcin_q};
            Z_P:     z_op = {1'b0, p_q};
            Z_C:     z_op = {1'b0, c_q};
            default: z_op = '0;
        endcase

        if (op_q[OP_SUB]) begin
            r = z_op - (x_op + cin_ext);
        end else begin
            r = z_op + x_op + cin_ext;
        end
    end

    dsp_pipe_reg #(.WIDTH(PWIDTH + 1), .ENABLE(1'b1)) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (CE),
        .d   (r),
        .q   (p_reg_q)
    );

    assign p_q      = p_reg_q[PWIDTH-1:0];
    assign CARRYOUT = p_reg_q[PWIDTH];
    assign P        = p_q;
    assign PCOUT    = p_q;

    dsp_pipe_reg #(.WIDTH(1), .ENABLE(MREG)) u_valid_m (
        .clk (clk),
        .rst (rst),
        .ce  (CE),
        .d   (in_valid),
        .q   (v_m)
    );

    dsp_pipe_reg #(.WIDTH(1), .ENABLE(1'b1)) u_valid_p (
        .clk (clk),
        .rst (rst),
        .ce  (CE),
        .d   (v_m),
        .q   (out_valid)
    );

endmodule

// File: tb/tb_dsp_mac_post_stage.sv
// Directed bench: MREG=1 instance checked through a result scoreboard, MREG=0 instance for the bypass path.
module tb_dsp_mac_post_stage;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic        [47:0] c;
    logic        [47:0] pcin;
    logic        [4:0]  opmode;
    logic               carryin;

    logic [47:0] p, pcout, p0, pcout0;
    logic        co, ov, co0, ov0;

    typedef struct {
        logic [47:0] p;
        logic        co;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   ce_cnt  = 0;

    always #5 clk = ~clk;

    dsp_mac_post_stage #(.WIDTH(18), .PWIDTH(48), .MREG(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .CE        (ce),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .C         (c),
        .PCIN      (pcin),
        .OPMODE    (opmode),
        .CARRYIN   (carryin),
        .P         (p),
        .PCOUT     (pcout),
        .CARRYOUT  (co),
        .out_valid (ov)
    );

    dsp_mac_post_stage #(.WIDTH(18), .PWIDTH(48), .MREG(1'b0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .CE        (ce),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .C         (c),
        .PCIN      (pcin),
        .OPMODE    (opmode),
        .CARRYIN   (carryin),
        .P         (p0),
        .PCOUT     (pcout0),
        .CARRYOUT  (co0),
        .out_valid (ov0)
    );

    task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp_v);
        cmp_cnt++;
        assert (obs === exp_v)
        else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        opmode   = 5'b00000;
        a        = '0;
        b        = '0;
        c        = '0;
        pcin     = '0;
        carryin  = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic signed [17:0] av,
                         input logic signed [17:0] bv, input logic [47:0] cv,
                         input logic [47:0] pv, input logic cin,
                         input logic [47:0] exp_p, input logic exp_co);
        exp_t e;
        in_valid = 1'b1;
        opmode   = op;
        a        = av;
        b        = bv;
        c        = cv;
        pcin     = pv;
        carryin  = cin;
        e.p      = exp_p;
        e.co     = exp_co;
        e.issue  = ce_cnt + 1;
        sb.push_back(e);
    endtask

    // One clock; a result is consumed only on edges where CE was high and reset low.
    task automatic tick();
        logic ce_at;
        logic rst_at;
        exp_t e;
        ce_at  = ce;
        rst_at = rst;
        @(posedge clk);
        if (ce_at && !rst_at) ce_cnt++;
        #1;
        chk("pcout_eq_p", {1'b0, pcout}, {1'b0, p});
        if (ce_at && !rst_at && ov) begin
            chk("result_expected", 49'(sb.size() != 0), 49'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("p_value", {1'b0, p}, {1'b0, e.p});
                chk("carryout", 49'(co), 49'(e.co));
                chk("latency", 49'(ce_cnt - e.issue + 1), 49'd2);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_p", 49'(p), 49'd0);
        chk("reset_co", 49'(co), 49'd0);
        chk("reset_valid", 49'(ov), 49'd0);
        rst = 1'b0;
        tick();

        // multiply-add: 3 * -4 + 100
        drive(5'b01101, 18'sd3, -18'sd4, 48'd100, 48'd0, 1'b0, 48'd88, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // D:A:B concatenation into X, Z=0
        drive(5'b00011, 18'sd1, 18'sd2, 48'hABC0_0000_0000, 48'd0, 1'b0, 48'hABC0_0004_0002, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // subtract borrow, then all-ones plus carry-in
        drive(5'b11101, 18'sd0, 18'sd0, 48'd0, 48'd0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1);
        tick();
        drive(5'b01101, 18'sd0, 18'sd0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 48'd0, 1'b1);
        tick();
        idle();
        tick();
        tick();

        // back-to-back accumulation
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd35, 1'b0);
        tick();
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd70, 1'b0);
        tick();
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd105, 1'b0);
        tick();
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd140, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // CE hold during accumulation while operands change
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd35, 1'b0);
        tick();
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd70, 1'b0);
        tick();
        ce = 1'b0;
        a  = 18'sd9;
        b  = 18'sd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_p", 49'(p), 49'd35);
            chk("hold_co", 49'(co), 49'd0);
            chk("hold_valid", 49'(ov), 49'd1);
        end
        ce = 1'b1;
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd105, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // async reset in the middle of accumulation
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd35, 1'b0);
        tick();
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd70, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_p", 49'(p), 49'd0);
        chk("async_rst_co", 49'(co), 49'd0);
        chk("async_rst_valid", 49'(ov), 49'd0);
        sb.delete();
        tick();
        chk("rst_wins_p", 49'(p), 49'd0);
        chk("rst_wins_valid", 49'(ov), 49'd0);
        rst = 1'b0;
        drive(5'b01001, 18'sd5, 18'sd7, 48'd0, 48'd0, 1'b0, 48'd35, 1'b0);
        tick();
        idle();
        tick();
        tick();

        // cascade input with the M stage bypassed on dut0
        drive(5'b00101, 18'sd2, 18'sd3, 48'd0, 48'd1000, 1'b0, 48'd1006, 1'b0);
        tick();
        chk("bypass_p", 49'(p0), 49'd1006);
        chk("bypass_pcout", 49'(pcout0), 49'd1006);
        chk("bypass_co", 49'(co0), 49'd0);
        chk("bypass_valid", 49'(ov0), 49'd1);
        idle();
        tick();
        chk("bypass_pcout_idle", 49'(pcout0), 49'd0);
        chk("bypass_valid_idle", 49'(ov0), 49'd0);
        tick();

        chk("queue_drained", 49'(sb.size()), 49'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
